if_prefetch_queue: RTL and testbench

- Decoupling buffer between Instruction_Fetch and ID_and_RF.
- Holds up to DEPTH fetched {pc, instruction} pairs.
- Lets fetch run ahead while decode stalls.
- Discards all buffered instructions when the Memory stage redirects the PC (PC_SRC).
- Tags each entry with a predecoded branch flag for downstream use.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/prefetch_queue_ram.sv | 26 ++
 rtl/if_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: the canonical NOP,
// the conditional-branch opcode, the fetch entry layout and a predecode helper.
package pipeline_pkg;

  localparam int          PC_W_DEF      = 64;
  localparam int          INSTR_W_DEF   = 32;
  localparam logic [31:0] NOP_INSTR     = 32'h00000013;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instruction;
    logic                   is_branch;
  } fetch_entry_t;

  function automatic logic is_branch_op(input logic [6:0] opcode);
    return (opcode == OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/prefetch_queue_ram.sv
// Entry storage for the prefetch queue: one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by the top.
module prefetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch-to-decode prefetch queue: buffers {pc, instruction, is_branch} entries,
// discards everything on a PC redirect, and presents the head from registers.
module if_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instruction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instruction,
  output logic                       out_is_branch,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PC_W + INSTR_W + 1;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [PC_W-1:0]    r_out_pc;
  logic [INSTR_W-1:0] r_out_instruction;
  logic               r_out_is_branch;

  logic               w_push;
  logic               w_pop;
  logic               w_we;
  logic               w_bypass;
  logic [PTR_W-1:0]   w_wr_next;
  logic [PTR_W-1:0]   w_rd_next;
  logic [CNT_W-1:0]   w_count_next;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic [ENTRY_W-1:0] w_head_next;

  assign w_push  = in_valid && r_in_ready;
  assign w_pop   = r_out_valid && out_ready;
  assign w_we    = w_push && !flush;
  assign w_wdata = {in_pc, in_instruction, is_branch_op(in_instruction[6:0])};

  // Next pointer/occupancy state; a redirect overrides any push or pop
  always_comb begin
    w_wr_next    = r_wr_ptr;
    w_rd_next    = r_rd_ptr;
    w_count_next = r_count;
    if (flush) begin
      w_wr_next    = {PTR_W{1'b0}};
      w_rd_next    = {PTR_W{1'b0}};
      w_count_next = {CNT_W{1'b0}};
    end else begin
      w_wr_next    = r_wr_ptr + PTR_W'(w_push);
      w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  prefetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_next),
    .o_rdata (w_rdata)
  );

  // The next head is the entry being written now when it lands on the next read slot
  assign w_bypass    = w_we && (w_rd_next == r_wr_ptr);
  assign w_head_next = w_bypass ? w_wdata : w_rdata;

  // State and registered head/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr          <= {PTR_W{1'b0}};
      r_rd_ptr          <= {PTR_W{1'b0}};
      r_count           <= {CNT_W{1'b0}};
      r_in_ready        <= 1'b1;
      r_out_valid       <= 1'b0;
      r_out_pc          <= {PC_W{1'b0}};
      r_out_instruction <= INSTR_W'(NOP_INSTR);
      r_out_is_branch   <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_next;
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_in_ready  <= (w_count_next != CNT_W'(DEPTH));
      r_out_valid <= (w_count_next != {CNT_W{1'b0}});
      if (w_count_next != {CNT_W{1'b0}}) begin
        r_out_pc          <= w_head_next[ENTRY_W-1 -: PC_W];
        r_out_instruction <= w_head_next[INSTR_W:1];
        r_out_is_branch   <= w_head_next[0];
      end else begin
        r_out_pc          <= r_out_pc;
        r_out_instruction <= INSTR_W'(NOP_INSTR);
        r_out_is_branch   <= 1'b0;
      end
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign out_pc          = r_out_pc;
  assign out_instruction = r_out_instruction;
  assign out_is_branch   = r_out_is_branch;
  assign count           = r_count;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_if_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_is_branch;
  logic        flush;
  logic [2:0]  count;

  if_prefetch_queue #(.DEPTH(DEPTH), .PC_W(64), .INSTR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_is_branch   (out_is_branch),
    .flush           (flush),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ref_entry_t;

  ref_entry_t  model_q[$];
  logic [63:0] model_last_pc;
  int          n_checks;
  int          n_errors;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's view of the queue
  task automatic check_all(input string tag);
    logic [31:0] e_ins;
    logic        e_br;
    if (model_q.size() > 0) begin
      model_last_pc = model_q[0].pc;
      e_ins         = model_q[0].ins;
      e_br          = (model_q[0].ins[6:0] == 7'b1100011);
    end else begin
      e_ins = 32'h00000013;
      e_br  = 1'b0;
    end
    check_val({tag, ".count"},     64'(count),           64'(model_q.size()));
    check_val({tag, ".out_valid"}, 64'(out_valid),       64'(model_q.size() > 0));
    check_val({tag, ".in_ready"},  64'(in_ready),        64'(model_q.size() < DEPTH));
    check_val({tag, ".out_pc"},    out_pc,               model_last_pc);
    check_val({tag, ".out_instr"}, 64'(out_instruction), 64'(e_ins));
    check_val({tag, ".out_isbr"},  64'(out_is_branch),   64'(e_br));
  endtask

  // One clock: apply inputs, advance the model at the edge, check at the falling edge
  task automatic step(input string tag, input logic v, input logic [63:0] pc,
                      input logic [31:0] ins, input logic rdy, input logic fl);
    bit do_push;
    bit do_pop;
    in_valid       = v;
    in_pc          = pc;
    in_instruction = ins;
    out_ready      = rdy;
    flush          = fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = rdy && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: pc, ins: ins});
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [31:0] r_ins;
    n_checks       = 0;
    n_errors       = 0;
    model_last_pc  = 64'd0;
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_pc          = 64'd0;
    in_instruction = 32'd0;
    out_ready      = 1'b0;
    flush          = 1'b0;

    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    step("idle", 1'b0, 64'd0, 32'd0, 1'b0, 1'b0);

    // Fill with decode stalled, then try a fifth push
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 64'(4 * i), 32'h007302B3, 1'b0, 1'b0);
    check_val("full.count", 64'(count), 64'd4);
    check_val("full.in_ready", 64'(in_ready), 64'd0);
    step("push5", 1'b1, 64'd16, 32'h007302B3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val("drain.pc", out_pc, 64'(4 * i));
      step("drain", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    end
    check_val("drain.empty", 64'(out_valid), 64'd0);

    // Steady push+pop at occupancy 2 across pointer wrap
    step("pp0", 1'b1, 64'h200, 32'h00100093, 1'b0, 1'b0);
    step("pp1", 1'b1, 64'h204, 32'h00200113, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step("pp", 1'b1, 64'h208 + 64'(4 * i), 32'h00300193 + 32'(i << 7), 1'b1, 1'b0);
      check_val("pp.count", 64'(count), 64'd2);
    end
    step("pp.d0", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    step("pp.d1", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // Branch predecode
    step("beq", 1'b1, 64'h20, 32'h005188E3, 1'b0, 1'b0);
    check_val("beq.isbr", 64'(out_is_branch), 64'd1);
    step("ld", 1'b1, 64'h24, 32'hC0263283, 1'b1, 1'b0);
    check_val("ld.isbr", 64'(out_is_branch), 64'd0);
    step("ld.pop", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) step("fl.fill", 1'b1, 64'h30 + 64'(4 * i), 32'h00000033, 1'b0, 1'b0);
    step("flush", 1'b1, 64'h40, 32'h00000033, 1'b1, 1'b1);
    check_val("flush.count", 64'(count), 64'd0);
    step("redir", 1'b1, 64'h100, 32'h00000063, 1'b0, 1'b0);
    check_val("redir.pc", out_pc, 64'h100);
    step("redir.pop", 1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step("ar.fill", 1'b1, 64'h500 + 64'(4 * i), 32'h00A00513, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    model_last_pc = 64'd0;
    check_val("areset.valid", 64'(out_valid), 64'd0);
    check_val("areset.count", 64'(count), 64'd0);
    check_all("areset");
    @(negedge clk);
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_ins = $urandom;
      if ($urandom_range(3) == 0) r_ins[6:0] = 7'b1100011;
      step("rand", 1'($urandom_range(3) != 0), {$urandom, $urandom}, r_ins,
           1'($urandom_range(2) != 0), 1'($urandom_range(15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
